// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: round-robin share of one combinational shifter between two requesters; ports: clk, rst_n, req0_*/req1_* (valid, ready, A, B, right, sign), sh_* (A, B, right, sign out; S in), rsp_valid/rsp_ready/rsp_id/rsp_data
module shift_unit_arbiter #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic        req0_right,
  input  logic        req0_sign,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  input  logic        req1_right,
  input  logic        req1_sign,
  output logic [31:0] sh_A,
  output logic [31:0] sh_B,
  output logic        sh_right,
  output logic        sh_sign,
  input  logic [31:0] sh_S,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  input  logic        rsp_ready
);
  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
  state_t state, state_n;
  logic rr_ptr, gid, gnt0, gnt1, any;
  logic [3:0] cnt;
  logic unused;
  assign unused = ^{req0_A[31:5], req1_A[31:5]};
  assign any = req0_valid | req1_valid;
  assign gnt0 = req0_valid & (~req1_valid | ~rr_ptr);
  assign gnt1 = req1_valid & (~req0_valid | rr_ptr);
  // ready is gated by rst_n so every output reads 0 while reset is held
  assign req0_ready = rst_n & (state == IDLE) & gnt0;
  assign req1_ready = rst_n & (state == IDLE) & gnt1;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE)  ? (any ? SHIFT : IDLE) :
              (state == SHIFT) ? ((cnt == 4'd0) ? RESP : SHIFT) :
              ((rsp_valid & rsp_ready) ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      gid       <= 1'b0;
      cnt       <= 4'd0;
      sh_A      <= 32'd0;
      sh_B      <= 32'd0;
      sh_right  <= 1'b0;
      sh_sign   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 32'd0;
    end else if (state == IDLE) begin
      if (any) begin
        gid      <= gnt1;
        cnt      <= 4'(SETTLE - 1);
        sh_A     <= {27'd0, gnt1 ? req1_A[4:0] : req0_A[4:0]};
        sh_B     <= gnt1 ? req1_B : req0_B;
        sh_right <= gnt1 ? req1_right : req0_right;
        // a signed left shift equals a logical one, so sign only matters for right shifts
        sh_sign  <= gnt1 ? (req1_right & req1_sign) : (req0_right & req0_sign);
      end
    end else if (state == SHIFT) begin
      if (cnt == 4'd0) begin
        rsp_data  <= sh_S;
        rsp_id    <= gid;
        rsp_valid <= 1'b1;
        rr_ptr    <= ~gid;
      end else cnt <= cnt - 4'd1;
    end else if (rsp_valid & rsp_ready) rsp_valid <= 1'b0;
  end
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb_shift_unit_arbiter: directed checks of arbitration, handshakes, shift results, latency and reset
module tb_shift_unit_arbiter;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req0_right = 0, req0_sign = 0, req0_ready;
  logic req1_valid = 0, req1_right = 0, req1_sign = 0, req1_ready;
  logic [31:0] req0_A = 0, req0_B = 0, req1_A = 0, req1_B = 0;
  logic [31:0] sh_A, sh_B, sh_S, rsp_data;
  logic sh_right, sh_sign, rsp_valid, rsp_id, rsp_ready = 0;
  logic v3 = 0, rt3 = 0, sg3 = 0, rdy3, rdy3b, zb = 0, rr3 = 0;
  logic [31:0] a3 = 0, b3 = 0, z32 = 0, sa3, sb3, ss3, rd3;
  logic sr3, ssg3, rv3, rid3;
  int pass_cnt = 0, tot_cnt = 0, n;
  logic [31:0] held;
  always #5 clk = ~clk;
  function automatic logic [31:0] shf(input logic [31:0] a, b, input logic r, s);
    shf = r ? (s ? 32'($signed(b) >>> a[4:0]) : b >> a[4:0]) : b << a[4:0];
  endfunction
  assign sh_S = shf(sh_A, sh_B, sh_right, sh_sign);
  assign ss3 = shf(sa3, sb3, sr3, ssg3);
  shift_unit_arbiter #(.SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req0_right(req0_right), .req0_sign(req0_sign),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .req1_right(req1_right), .req1_sign(req1_sign),
    .sh_A(sh_A), .sh_B(sh_B), .sh_right(sh_right), .sh_sign(sh_sign), .sh_S(sh_S),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready));
  shift_unit_arbiter #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v3), .req0_ready(rdy3), .req0_A(a3), .req0_B(b3),
    .req0_right(rt3), .req0_sign(sg3),
    .req1_valid(zb), .req1_ready(rdy3b), .req1_A(z32), .req1_B(z32),
    .req1_right(zb), .req1_sign(zb),
    .sh_A(sa3), .sh_B(sb3), .sh_right(sr3), .sh_sign(ssg3), .sh_S(ss3),
    .rsp_valid(rv3), .rsp_id(rid3), .rsp_data(rd3), .rsp_ready(rr3));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic wait_rsp();
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic do_op(input logic id, input logic [31:0] a, b, input logic r, s, input logic [31:0] exp);
    @(negedge clk);
    if (id) {req1_valid, req1_A, req1_B, req1_right, req1_sign} = {1'b1, a, b, r, s};
    else {req0_valid, req0_A, req0_B, req0_right, req0_sign} = {1'b1, a, b, r, s};
    #1 check("ready", {31'd0, id ? req1_ready : req0_ready}, 1);
    @(negedge clk);
    {req0_valid, req1_valid} = 0;
    {req0_A, req0_B, req1_A, req1_B} = {4{32'hffff_ffff}};
    check("sh_sign", {31'd0, sh_sign}, {31'd0, r & s});
    wait_rsp();
    check("latency", n, 2);
    check("rsp_id", {31'd0, rsp_id}, {31'd0, id});
    check("rsp_data", rsp_data, exp);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("rsp_drop", {31'd0, rsp_valid}, 0);
  endtask
  initial begin
    req0_valid = 1;
    #2;
    check("rst_ready0", {31'd0, req0_ready}, 0);
    check("rst_outs", {sh_A[15:0], sh_B[7:0], 4'd0, sh_right, sh_sign, rsp_valid, rsp_id}, 0);
    check("rst_data", rsp_data, 0);
    @(negedge clk);
    req0_valid = 0;
    rst_n = 1;
    do_op(0, 4, 24, 0, 0, 384);
    do_op(1, 4, 24, 1, 0, 1);
    do_op(1, 88888, 9, 0, 0, 32'h0900_0000);
    do_op(0, 25, 32'hF8A4_32EB, 1, 0, 32'h0000_007C);
    do_op(0, 25, 32'hF8A4_32EB, 1, 1, 32'hFFFF_FFFC);
    do_op(1, 4, 24, 0, 1, 384);
    @(negedge clk);
    {req0_valid, req0_A, req0_B, req0_right, req0_sign} = {1'b1, 32'd3, 32'd5, 1'b0, 1'b0};
    @(negedge clk);
    req0_valid = 0;
    wait_rsp();
    held = rsp_data;
    check("t5_data", held, 40);
    {req0_valid, req1_valid} = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_valid", {31'd0, rsp_valid}, 1);
      check("t5_hold", rsp_data, held);
      check("t5_rdy", {30'd0, req1_ready, req0_ready}, 0);
    end
    rsp_ready = 1;
    {req0_valid, req1_valid} = 0;
    @(negedge clk);
    rsp_ready = 0;
    check("t5_drop", {31'd0, rsp_valid}, 0);
    @(negedge clk);
    {req0_valid, req0_A, req0_B} = {1'b1, 32'd1, 32'd7};
    @(negedge clk);
    req0_valid = 0;
    rst_n = 0;
    #1 check("t6_shift", {sh_B[30:0], rsp_valid}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    check("t6_stale1", {31'd0, rsp_valid}, 0);
    req0_valid = 1;
    @(negedge clk);
    req0_valid = 0;
    wait_rsp();
    check("t6_resp", rsp_data, 14);
    #1 rst_n = 0;
    #1 check("t6_rdata", rsp_data, 0);
    check("t6_rvalid", {31'd0, rsp_valid}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    check("t6_stale2", {31'd0, rsp_valid}, 0);
    {req0_A, req0_B, req0_right, req0_sign} = {32'd1, 32'd3, 1'b0, 1'b0};
    {req1_A, req1_B, req1_right, req1_sign} = {32'd2, 32'd3, 1'b0, 1'b0};
    {req0_valid, req1_valid} = 2'b11;
    rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid && n < 10);
      check("t4_id", {31'd0, rsp_id}, k % 2);
      check("t4_data", rsp_data, (k % 2) ? 12 : 6);
    end
    {req0_valid, req1_valid} = 0;
    @(negedge clk);
    rsp_ready = 0;
    {v3, a3, b3} = {1'b1, 32'd3, 32'd1};
    #1 check("s3_ready", {31'd0, rdy3}, 1);
    @(negedge clk);
    v3 = 0;
    n = 1;
    while (!rv3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("s3_latency", n, 4);
    check("s3_data", rd3, 8);
    rr3 = 1;
    @(negedge clk);
    rr3 = 0;
    check("s3_drop", {31'd0, rv3}, 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
